// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the memory-mapped UART
//                transmitter: FSM state encoding, register offsets and
//                STATUS bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // One-hot transmitter states
  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StStart = 4'b0010,
    StData  = 4'b0100,
    StStop  = 4'b1000
  } uart_state_e;

  // Word offsets from the block base address
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;

  // STATUS register bit positions
  localparam int StatFull     = 0;
  localparam int StatEmpty    = 1;
  localparam int StatBusy     = 2;
  localparam int StatOverflow = 3;
  localparam int StatCountLsb = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : SyncFifo
//  Description : Single-clock FIFO with combinational head output. A pop on
//                an empty FIFO is ignored; a push on a full FIFO is accepted
//                only when a pop frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module SyncFifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_full_count);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array: written only on accepted pushes, contents need no reset
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : SyncFifo
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port
//  Description : Bus-attached 8N1 UART transmitter. Bytes written to DATA
//                are queued in a FIFO and serialised LSB first on txd.
//                STATUS exposes full/empty/busy/overflow and FIFO count.
//                Read data is registered and zero when not selected.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port
  import uart_pkg::*;
#(
  parameter logic [29:0] BASE    = 30'h3fff_fff0,
  parameter int          DIVISOR = 868,
  parameter int          DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        txd
);

  localparam int CW = $clog2(DEPTH);
  localparam int DW = $clog2(DIVISOR);
  localparam logic [DW-1:0] c_div_last = DW'(DIVISOR - 1);

  uart_state_e r_state;
  uart_state_e w_state_next;
  logic [DW-1:0] r_div_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_ovf;
  logic [31:0]   r_rdata;

  logic [29:0]   w_off;
  logic          w_sel;
  logic          w_push;
  logic          w_clr;
  logic          w_rd;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [CW:0]   w_count;
  logic [7:0]    w_dout;
  logic          w_pop;
  logic          w_div_end;
  logic [7:0]    w_shift_next;
  logic          w_txd_next;
  logic [31:0]   w_status;
  logic          w_unused_data;

  // Subtracting the base keeps decode correct even for unaligned BASE values
  assign w_off     = bus_addr - BASE;
  assign w_sel     = (w_off[29:2] == '0);
  assign w_push    = w_sel & (w_off[1:0] == RegData)   & bus_mask_w[0];
  assign w_clr     = w_sel & (w_off[1:0] == RegStatus) & bus_mask_w[0] & bus_data_w[StatOverflow];
  assign w_rd      = w_sel & (bus_mask_w == 4'b0000);
  // A full FIFO drops the byte unless the transmitter pops in the same cycle
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_div_end = (r_div_cnt == c_div_last);
  assign w_unused_data = ^bus_data_w[31:8];

  assign bus_data_r = r_rdata;
  assign txd        = r_txd;

  SyncFifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus_data_w[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Assemble the STATUS word from live state
  always_comb begin
    w_status                         = '0;
    w_status[StatFull]               = w_full;
    w_status[StatEmpty]              = w_empty;
    w_status[StatBusy]               = (r_state != StIdle);
    w_status[StatOverflow]           = r_ovf;
    w_status[StatCountLsb +: 8]      = 8'(w_count);
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (w_clr)   r_ovf <= 1'b0;
  end

  // Registered read port, zero when unselected so it can be ORed with RAM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rdata <= '0;
    else        r_rdata <= (w_rd && (w_off[1:0] == RegStatus)) ? w_status : '0;
  end

  // FSM state, bit timing counters, shift register and registered txd
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
      if (r_state == StIdle || w_div_end) r_div_cnt <= '0;
      else                                r_div_cnt <= r_div_cnt + 1'b1;
      // 3-bit counter wraps back to 0 after the eighth data bit
      if (r_state == StData && w_div_end) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_next = StStart;
      StStart: if (w_div_end) w_state_next = StData;
      StData:  if (w_div_end && r_bit_cnt == 3'd7) w_state_next = StStop;
      StStop:  if (w_div_end) w_state_next = w_empty ? StIdle : StStart;
      default: w_state_next = StIdle;
    endcase
  end

  // Pop, shift and line-level decisions, computed ahead of the txd register
  always_comb begin
    w_pop = (!w_empty) && ((r_state == StIdle) || (r_state == StStop && w_div_end));
    w_shift_next = r_shift;
    if (w_pop)                               w_shift_next = w_dout;
    else if (r_state == StData && w_div_end) w_shift_next = r_shift >> 1;
    case (w_state_next)
      StStart: w_txd_next = 1'b0;
      StData:  w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

endmodule : uart_tx_port
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_port
//  Description : Self-checking bench for uart_tx_port. A queue-based line
//                model predicts txd and registered read data every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;

  localparam int          DIV  = 4;
  localparam int          DEP  = 4;
  localparam logic [29:0] BASE = 30'h100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] bus_addr = BASE + 30'd1;
  logic [31:0] bus_data_w = '0;
  logic [3:0]  bus_mask_w = '0;
  logic [31:0] bus_data_r;
  logic        txd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Line model: pending bytes, current frame byte and elapsed cycles
  logic [7:0]  m_q[$];
  bit          m_active;
  int          m_t;
  logic [7:0]  m_byte;
  bit          m_ovf;
  logic [31:0] m_rd;

  always #5 clock = ~clock;

  uart_tx_port #(.BASE(BASE), .DIVISOR(DIV), .DEPTH(DEP)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r),
    .txd        (txd)
  );

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    int n = m_q.size();
    return {16'h0, 8'(n), 4'h0, m_ovf, m_active, (n == 0), (n == DEP)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_t = 0; m_byte = '0; m_ovf = 0; m_rd = '0;
  endtask

  // Apply one rising edge to the model using the bus inputs present at it
  task automatic model_edge();
    logic [29:0] off;
    int  pre;
    bit  popped, pw, clr;
    off    = bus_addr - BASE;
    pre    = m_q.size();
    popped = 0;
    m_rd   = (off == 30'd1 && bus_mask_w == 4'd0) ? model_status() : 32'd0;
    pw     = (off == 30'd0) && bus_mask_w[0];
    clr    = (off == 30'd1) && bus_mask_w[0] && bus_data_w[3];
    if (!m_active) begin
      if (pre > 0) begin m_byte = m_q.pop_front(); m_active = 1; m_t = 0; popped = 1; end
    end else begin
      m_t++;
      if (m_t == 10*DIV) begin
        if (pre > 0) begin m_byte = m_q.pop_front(); m_t = 0; popped = 1; end
        else begin m_active = 0; m_t = 0; end
      end
    end
    if (pw && !(pre < DEP || popped)) m_ovf = 1;
    else if (pw) begin m_q.push_back(bus_data_w[7:0]); if (clr) m_ovf = 0; end
    else if (clr) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_edge();
    @(negedge clock);
    cyc++;
  endtask

  task automatic bus_set(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_addr = a; bus_data_w = d; bus_mask_w = m;
  endtask

  task automatic test_reset();
    model_reset();
    bus_set(BASE + 30'd1, 32'd0, 4'd0);
    repeat (3) @(negedge clock);
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    n_checks++;
    if (bus_data_r !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", bus_data_r); end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if (txd !== exp_txd()) begin n_errors++; $display("FAIL idle_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      n_checks++;
      if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL idle_status cyc=%0d got=%h exp=%h", cyc, bus_data_r, m_rd); end
    end
    n_checks++;
    if (bus_data_r !== 32'h0000_0002) begin n_errors++; $display("FAIL reset_status got=%h exp=00000002", bus_data_r); end
  endtask

  task automatic test_single(input logic [7:0] b);
    bus_set(BASE, {$urandom()} << 8 | {24'h0, b}, 4'b0001);
    tick();
    bus_set(BASE + 30'd1, 32'd0, 4'd0);
    for (int i = 0; i < 45; i++) begin
      tick();
      n_checks++;
      if (txd !== exp_txd()) begin n_errors++; $display("FAIL single_txd byte=%h cyc=%0d got=%b exp=%b", b, cyc, txd, exp_txd()); end
      n_checks++;
      if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL single_status cyc=%0d got=%h exp=%h", cyc, bus_data_r, m_rd); end
    end
  endtask

  task automatic test_back_to_back();
    bus_set(BASE, {24'h0, 8'($urandom())}, 4'b0001);
    tick();
    bus_set(BASE, {24'h0, 8'($urandom())}, 4'b0001);
    tick();
    bus_set(BASE + 30'd1, 32'd0, 4'd0);
    for (int i = 0; i < 85; i++) begin
      tick();
      n_checks++;
      if (txd !== exp_txd()) begin n_errors++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      n_checks++;
      if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL b2b_status cyc=%0d got=%h exp=%h", cyc, bus_data_r, m_rd); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      bus_set(BASE, {24'h0, 8'($urandom())}, 4'b0001);
      tick();
    end
    bus_set(BASE + 30'd1, 32'd0, 4'd0);
    tick();
    n_checks++;
    if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL ovf_status got=%h exp=%h", bus_data_r, m_rd); end
    n_checks++;
    if (bus_data_r[3] !== 1'b1 || bus_data_r[15:8] !== 8'd4) begin
      n_errors++; $display("FAIL ovf_flag_count got=%h exp_ovf=1 exp_count=4", bus_data_r);
    end
    bus_set(BASE + 30'd1, 32'h8, 4'b0001);
    tick();
    bus_set(BASE + 30'd1, 32'd0, 4'd0);
    tick();
    n_checks++;
    if (bus_data_r[3] !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got=%h exp_bit3=0", bus_data_r); end
    for (int i = 0; i < 220; i++) begin
      tick();
      n_checks++;
      if (txd !== exp_txd()) begin n_errors++; $display("FAIL ovf_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      n_checks++;
      if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, bus_data_r, m_rd); end
    end
  endtask

  task automatic test_reset_midframe();
    bus_set(BASE, {24'h0, 8'h00}, 4'b0001);
    tick();
    bus_set(BASE + 30'd1, 32'd0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      tick();
      n_checks++;
      if (txd !== exp_txd()) begin n_errors++; $display("FAIL mid_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL mid_async_txd got=%b exp=1", txd); end
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus_data_r !== 32'h0000_0002) begin n_errors++; $display("FAIL mid_status got=%h exp=00000002", bus_data_r); end
    test_single(8'($urandom()));
  endtask

  task automatic test_reserved();
    logic [29:0] addrs[4];
    addrs = '{30'h102, 30'h103, 30'h0ff, 30'h104};
    bus_set(BASE + 30'd2, 32'hffff_ffff, 4'b1111);
    tick();
    bus_set(30'h0ff, 32'hffff_ffff, 4'b1111);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_set(BASE + 30'd1, 32'd0, 4'd0);
      tick();
      n_checks++;
      if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL rsv_status got=%h exp=%h", bus_data_r, m_rd); end
      bus_set(addrs[i], 32'd0, 4'd0);
      tick();
      n_checks++;
      if (bus_data_r !== 32'd0) begin n_errors++; $display("FAIL rsv_read addr=%h got=%h exp=0", addrs[i], bus_data_r); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 650; i++) begin
      r = (i < 400) ? int'($urandom_range(0, 9)) : 9;
      case (r)
        0, 1, 2: bus_set(BASE, $urandom(), 4'b0001);
        3:       bus_set(BASE + 30'd1, $urandom() | 32'h8, 4'($urandom_range(1, 15)));
        4:       bus_set(BASE - 30'd2 + 30'($urandom_range(0, 7)), $urandom(), 4'($urandom_range(0, 15)));
        5:       bus_set(BASE - 30'd1 + 30'($urandom_range(0, 5)), 32'd0, 4'd0);
        default: bus_set(BASE + 30'd1, 32'd0, 4'd0);
      endcase
      tick();
      n_checks++;
      if (txd !== exp_txd()) begin n_errors++; $display("FAIL rand_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      n_checks++;
      if (bus_data_r !== m_rd) begin n_errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, bus_data_r, m_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom()));
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_reserved();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_port
`default_nettype wire
